// File: rtl/sarlock_pkg.sv
// Shared definitions for the SAR-lock key path: default key width, loader states,
// and the all-zero key driven while the core is locked.
package sarlock_pkg;

  localparam int unsigned KEY_W_DEF = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SHIFT = 3'd1,
    PAR   = 3'd2,
    CHECK = 3'd3,
    ERR   = 3'd4
  } loader_state_t;

  localparam logic [KEY_W_DEF-1:0] ZERO_KEY = '0;

endpackage

// File: rtl/sarlock_timeout_ctr.sv
// Saturating idle-cycle counter for the key loader; o_hit flags that TIMEOUT idle
// cycles have elapsed. TIMEOUT = 0 disables the hit entirely.
module sarlock_timeout_ctr #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_inc,
  output logic o_hit
);

  localparam int unsigned CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  logic [CW-1:0] r_cnt;
  logic          w_at_max;

  assign w_at_max = (r_cnt == CW'(TIMEOUT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_inc && !w_at_max) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_hit = (TIMEOUT != 0) && w_at_max;

endmodule

// File: rtl/sarlock_key_loader.sv
// Serial key loader for the SAR-locked core: shifts in KEY_W bits plus an even-parity
// bit over valid/ready and commits the key only when parity checks.
import sarlock_pkg::*;

module sarlock_key_loader #(
  parameter int unsigned KEY_W   = KEY_W_DEF,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sdata,
  input  logic             svalid,
  output logic             sready,
  output logic [KEY_W-1:0] key_out,
  output logic             key_valid,
  output logic             busy,
  output logic             err
);

  localparam int unsigned CNT_W = $clog2(KEY_W + 1);

  loader_state_t    r_state;
  loader_state_t    w_next;
  logic [KEY_W-1:0] r_shadow;
  logic [CNT_W-1:0] r_cnt;
  logic             r_par;
  logic             w_hs;
  logic             w_hit;
  logic             w_restart;
  logic             w_par_ok;
  logic             w_last_bit;

  // sready/busy come from the state register only, so no input reaches them combinationally.
  assign sready     = (r_state == SHIFT) || (r_state == PAR);
  assign busy       = sready || (r_state == CHECK);
  assign w_hs       = svalid && sready;
  assign w_restart  = start && (r_state != CHECK);
  assign w_par_ok   = ((^r_shadow) == r_par);
  assign w_last_bit = (r_cnt == CNT_W'(KEY_W - 1));

  sarlock_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_tmo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clear (!sready || w_hs || start),
    .i_inc   (sready && !w_hs),
    .o_hit   (w_hit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (start) w_next = SHIFT;
      end
      SHIFT: begin
        if (start)                   w_next = SHIFT;
        else if (w_hit)              w_next = ERR;
        else if (w_hs && w_last_bit) w_next = PAR;
      end
      PAR: begin
        if (start)      w_next = SHIFT;
        else if (w_hit) w_next = ERR;
        else if (w_hs)  w_next = CHECK;
      end
      CHECK: begin
        w_next = w_par_ok ? IDLE : ERR;
      end
      ERR: begin
        if (start) w_next = SHIFT;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow <= '0;
      r_cnt    <= '0;
      r_par    <= 1'b0;
    end else if (w_restart) begin
      r_shadow <= '0;
      r_cnt    <= '0;
    end else if (w_hs) begin
      if (r_state == SHIFT) begin
        r_shadow <= {r_shadow[KEY_W-2:0], sdata};
        if (r_cnt != CNT_W'(KEY_W)) r_cnt <= r_cnt + 1'b1;
      end else begin
        r_par <= sdata;
      end
    end
  end

  // The previously committed key survives a new load until CHECK or a timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_out   <= '0;
      key_valid <= 1'b0;
      err       <= 1'b0;
    end else if (r_state == CHECK) begin
      if (w_par_ok) begin
        key_out   <= r_shadow;
        key_valid <= 1'b1;
      end else begin
        key_out   <= '0;
        key_valid <= 1'b0;
        err       <= 1'b1;
      end
    end else if (w_restart) begin
      err <= 1'b0;
    end else if (sready && w_hit) begin
      key_out   <= '0;
      key_valid <= 1'b0;
      err       <= 1'b1;
    end
  end

endmodule
